// File: rtl/mult_pipe_manager.sv
// mult_pipe_manager: pipelined RV32M multiplier with per-stage rd tracking and valid/ready write-back
// Ports: issue_* take MUL/MULH/MULHSU/MULHU from EX (issue_ready_o = pipeline can advance);
//        mult_uses_o / rd_addrs_mult_o expose per-stage occupancy and rd to the ID stall logic;
//        wb_* present the last-stage result to the write-back arbiter.
module mult_pipe_manager #(
    parameter int PPL_STAGE = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [1:0]           issue_op_i,
    input  logic [4:0]           issue_rd_addr_i,
    input  logic [XLEN-1:0]      issue_rs1_i,
    input  logic [XLEN-1:0]      issue_rs2_i,
    output logic [PPL_STAGE-1:0] mult_uses_o,
    output logic [4:0]           rd_addrs_mult_o [PPL_STAGE],
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [4:0]           wb_rd_addr_o,
    output logic [XLEN-1:0]      wb_data_o
);
    logic adv, take, sa, sb;
    logic [1:0] op_q [PPL_STAGE];
    logic [XLEN:0] a_q, b_q;
    logic [2*XLEN-1:0] a_x, b_x, prod_d;
    logic [2*XLEN-1:0] prod_q [1:PPL_STAGE-1];
    assign adv = !(mult_uses_o[PPL_STAGE-1] && !wb_ready_i);
    assign issue_ready_o = adv;
    // rd=0 ops flow through the datapath but are never tracked or written back
    assign take = issue_valid_i && |issue_rd_addr_i;
    assign sa = issue_op_i[0] ^ issue_op_i[1];
    assign sb = issue_op_i == 2'b01;
    // low 2*XLEN bits of the 33x33 signed product equal the modular product of the sign-extended operands
    assign a_x = {{(XLEN-1){a_q[XLEN]}}, a_q};
    assign b_x = {{(XLEN-1){b_q[XLEN]}}, b_q};
    assign prod_d = a_x * b_x;
    assign wb_valid_o = mult_uses_o[PPL_STAGE-1];
    assign wb_rd_addr_o = rd_addrs_mult_o[PPL_STAGE-1];
    assign wb_data_o = op_q[PPL_STAGE-1] == 2'b00 ? prod_q[PPL_STAGE-1][XLEN-1:0]
                                                  : prod_q[PPL_STAGE-1][2*XLEN-1:XLEN];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_uses_o <= '0;
            a_q <= '0;
            b_q <= '0;
            for (int i = 0; i < PPL_STAGE; i++) begin
                rd_addrs_mult_o[i] <= '0;
                op_q[i] <= '0;
            end
            for (int i = 1; i < PPL_STAGE; i++) prod_q[i] <= '0;
        end else if (adv) begin
            mult_uses_o <= {mult_uses_o[PPL_STAGE-2:0], take};
            rd_addrs_mult_o[0] <= take ? issue_rd_addr_i : 5'd0;
            op_q[0] <= issue_op_i;
            a_q <= {sa & issue_rs1_i[XLEN-1], issue_rs1_i};
            b_q <= {sb & issue_rs2_i[XLEN-1], issue_rs2_i};
            for (int i = 1; i < PPL_STAGE; i++) begin
                rd_addrs_mult_o[i] <= rd_addrs_mult_o[i-1];
                op_q[i] <= op_q[i-1];
            end
            prod_q[1] <= prod_d;
            for (int i = 2; i < PPL_STAGE; i++) prod_q[i] <= prod_q[i-1];
        end
    end
endmodule
